// File: rtl/ss_reader.sv
// ---------------------------------------------------------------------------
// ss_reader
//
// Collects eight 7-segment patterns, one per accepted beat, decodes each
// into a hex nibble and publishes the completed frame on digits/bad with a
// one-cycle done pulse. An unrecognised pattern decodes to 0 with its bad bit
// set. A blank pattern (all segments off) decodes to 0 with its bad bit clear.
//
// Optional feature: define SS_READER_NINESCOMP_EN to add the comp output.
// comp carries the nines complement of each decimal digit, and 0 for the
// digits A-F. comp is registered together with digits.
//
// Ports
//   hz100      in   1   clock; all state updates on the rising edge
//   reset      in   1   synchronous reset, active low
//   seg_in     in   7   segment pattern, bit0 = a ... bit6 = g, 1 = lit
//   seg_valid  in   1   seg_in holds a beat
//   seg_ready  out  1   block can accept a beat (low only in the DONE cycle)
//   digits     out 32   last completed frame; first beat in [31:28]
//   bad        out  8   per-digit unrecognised flag; bit 7 pairs with [31:28]
//   done       out  1   one-cycle pulse when digits/bad update
//   busy       out  1   high while a frame is partially received
//   comp       out 32   (SS_READER_NINESCOMP_EN only) nines complement of digits
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ss_reader (
    input  logic        hz100,
    input  logic        reset,
    input  logic [6:0]  seg_in,
    input  logic        seg_valid,
    output logic        seg_ready,
    output logic [31:0] digits,
    output logic [7:0]  bad,
    output logic        done,
    output logic        busy
`ifdef SS_READER_NINESCOMP_EN
    ,
    output logic [31:0] comp
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state_q;
    logic [2:0]  count_q;
    logic [31:0] work_q;
    logic [7:0]  work_bad_q;
    logic [31:0] digits_q;
    logic [7:0]  bad_q;
    logic        done_q;
    logic        busy_q;
    logic        ready_q;

    logic        accept;
    logic [3:0]  dec_nib;
    logic        dec_bad;
    logic [31:0] work_d;
    logic [7:0]  work_bad_d;

    assign accept = seg_valid & ready_q;

    // Pattern decode for the beat currently on seg_in.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        dec_nib = 4'h0;
        dec_bad = 1'b0;
        case (seg_in)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h67: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            7'h00: dec_bad = 1'b0;   // blank: valid, reads as 0
            default: dec_bad = 1'b1;
        endcase
    end

    // Working registers after shifting in the current beat. On the 8th beat
    // these are the complete frame, which is published straight from here so
    // digits/bad already hold it during the DONE cycle.
    assign work_d     = {work_q[27:0], dec_nib};
    assign work_bad_d = {work_bad_q[6:0], dec_bad};

`ifdef SS_READER_NINESCOMP_EN
    logic [31:0] comp_q;
    logic [31:0] comp_d;

    always_comb begin
        comp_d = '0;
        for (int i = 0; i < 8; i++) begin
            if (work_d[4*i +: 4] <= 4'd9) begin
                comp_d[4*i +: 4] = 4'd9 - work_d[4*i +: 4];
            end
        end
    end

    assign comp = comp_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge hz100) begin
        // NOTE: the output frame registers are reset because they are visible
        // ports. The working shift registers are reset to keep their state
        // well defined, even though a full frame always overwrites them.
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= 3'd0;
            work_q     <= '0;
            work_bad_q <= '0;
            digits_q   <= '0;
            bad_q      <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
`ifdef SS_READER_NINESCOMP_EN
            comp_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= COLLECT;
                        count_q    <= 3'd1;
                        work_q     <= work_d;
                        work_bad_q <= work_bad_d;
                        busy_q     <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        count_q    <= count_q + 3'd1;   // wraps to 0 on the 8th beat
                        work_q     <= work_d;
                        work_bad_q <= work_bad_d;
                        if (count_q == 3'd7) begin
                            state_q  <= DONE;
                            digits_q <= work_d;
                            bad_q    <= work_bad_d;
`ifdef SS_READER_NINESCOMP_EN
                            comp_q   <= comp_d;
`endif
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            ready_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign seg_ready = ready_q;
    assign digits    = digits_q;
    assign bad       = bad_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ss_reader.sv
// ---------------------------------------------------------------------------
// tb_ss_reader
//
// Self-checking bench for ss_reader. The reference model keeps the accepted
// beats of the current frame in a queue. When the eighth beat arrives, the
// model builds the frame arithmetically from a lookup of the segment table.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ss_reader;

    logic        hz100 = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  seg_in = 7'h00;
    logic        seg_valid = 1'b0;
    logic        seg_ready;
    logic [31:0] digits;
    logic [7:0]  bad;
    logic        done;
    logic        busy;
`ifdef SS_READER_NINESCOMP_EN
    logic [31:0] comp;
`endif

    ss_reader dut (
        .hz100     (hz100),
        .reset     (reset),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .digits    (digits),
        .bad       (bad),
        .done      (done),
        .busy      (busy)
`ifdef SS_READER_NINESCOMP_EN
        ,
        .comp      (comp)
`endif
    );

    always #5 hz100 = ~hz100;

    int vectors     = 0;
    int miscompares = 0;

    // Segment patterns for hex digits 0..F.
    logic [6:0] patt [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state.
    logic [6:0]  m_beats [$];
    logic [31:0] m_digits  = '0;
    logic [7:0]  m_bad     = '0;
    logic [31:0] m_comp    = '0;
    logic        m_done    = 1'b0;
    logic        m_in_done = 1'b0;

    function automatic void model_decode(input logic [6:0] p, output logic [3:0] n, output logic f);
        n = 4'h0;
        f = (p != 7'h00);
        for (int i = 0; i < 16; i++) begin
            if (patt[i] == p) begin
                n = 4'(i);
                f = 1'b0;
            end
        end
    endfunction

    // Expected {seg_ready, busy, done, bad, digits}.
    function automatic logic [42:0] model_vec();
        return {!m_in_done, (m_beats.size() != 0), m_done, m_bad, m_digits};
    endfunction

    // Apply one cycle of stimulus and advance the model across the edge.
    // Returns whether the model says the beat was accepted.
    task automatic drive_cycle(input logic v, input logic [6:0] s, input logic r, output logic acc);
        logic [3:0] n;
        logic       f;
        logic [31:0] d;
        logic [7:0]  b;
        seg_valid = v;
        seg_in    = s;
        reset     = r;
        @(posedge hz100);
        acc = 1'b0;
        if (!r) begin
            m_beats.delete();
            m_digits  = '0;
            m_bad     = '0;
            m_comp    = '0;
            m_done    = 1'b0;
            m_in_done = 1'b0;
        end else if (m_in_done) begin
            m_in_done = 1'b0;
            m_done    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (v) begin
                acc = 1'b1;
                m_beats.push_back(s);
                if (m_beats.size() == 8) begin
                    d = 0;
                    b = 0;
                    foreach (m_beats[i]) begin
                        model_decode(m_beats[i], n, f);
                        d = d * 16 + 32'(n);
                        b = b * 2 + 8'(f);
                    end
                    m_digits = d;
                    m_bad    = b;
                    m_comp   = 0;
                    for (int k = 7; k >= 0; k--) begin
                        int dig;
                        dig = (d / (1 << (4 * k))) % 16;
                        m_comp = m_comp * 16 + ((dig <= 9) ? 32'(9 - dig) : 32'd0);
                    end
                    m_beats.delete();
                    m_in_done = 1'b1;
                    m_done    = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic acc;
        logic [42:0] obs;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 7'($urandom), (i == 3), acc);
            obs = {seg_ready, busy, done, bad, digits};
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL reset cyc%0d: rdy/busy/done/bad/digits got %h expected %h", i, obs, model_vec());
            end
        end
        // The beat presented on the release cycle above was accepted, so flush
        // with a fresh reset before the directed frames.
        drive_cycle(1'b0, 7'h00, 1'b0, acc);
        drive_cycle(1'b0, 7'h00, 1'b1, acc);
        obs = {seg_ready, busy, done, bad, digits};
        vectors++;
        if (obs !== 43'h400_0000_0000) begin
            miscompares++;
            $display("FAIL reset_idle: rdy/busy/done/bad/digits got %h expected %h", obs, 43'h400_0000_0000);
        end
    endtask

    task automatic test_known_frame();
        logic [6:0] f [8] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F};
        logic acc;
        logic [42:0] obs;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, f[i], 1'b1, acc);
            obs = {seg_ready, busy, done, bad, digits};
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL known_frame beat%0d: got %h expected %h", i, obs, model_vec());
            end
        end
        vectors++;
        if (done !== 1'b1 || digits !== 32'h12345678 || bad !== 8'h00 || seg_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL known_frame_done: done=%b digits=%h bad=%h rdy=%b expected 1/12345678/00/0",
                     done, digits, bad, seg_ready);
        end
        drive_cycle(1'b0, 7'h00, 1'b1, acc);
        vectors++;
        if (done !== 1'b0 || seg_ready !== 1'b1 || digits !== 32'h12345678) begin
            miscompares++;
            $display("FAIL known_frame_after: done=%b rdy=%b digits=%h expected 0/1/12345678", done, seg_ready, digits);
        end
    endtask

    task automatic test_toggle_valid();
        logic [6:0] f [8] = '{7'h3F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        logic acc;
        logic [42:0] obs;
        int k = 0;
        int cyc = 0;
        while (k < 8 && cyc < 40) begin
            drive_cycle((cyc % 2) == 0, f[k], 1'b1, acc);
            if (acc) k++;
            cyc++;
            obs = {seg_ready, busy, done, bad, digits};
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL toggle cyc%0d: got %h expected %h", cyc, obs, model_vec());
            end
        end
        vectors++;
        if (k != 8 || digits !== 32'h09ABCDEF || bad !== 8'h00) begin
            miscompares++;
            $display("FAIL toggle_frame: beats=%0d digits=%h bad=%h expected 8/09abcdef/00", k, digits, bad);
        end
        drive_cycle(1'b0, 7'h00, 1'b1, acc);
    endtask

    task automatic test_bad_patterns();
        logic [6:0] f [8] = '{7'h3F, 7'h3F, 7'h7E, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00};
        logic acc;
        logic [42:0] obs;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, f[i], 1'b1, acc);
            obs = {seg_ready, busy, done, bad, digits};
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL bad_frame beat%0d: got %h expected %h", i, obs, model_vec());
            end
        end
        vectors++;
        if (digits !== 32'h0 || bad !== 8'b0010_0000) begin
            miscompares++;
            $display("FAIL bad_flags: digits=%h bad=%b expected 00000000/00100000", digits, bad);
        end
        drive_cycle(1'b0, 7'h00, 1'b1, acc);
    endtask

    task automatic test_mid_reset();
        logic acc;
        logic [42:0] obs;
        for (int i = 0; i < 14; i++) begin
            // 5 random beats, one reset cycle with a beat present, 8 beats of "1".
            if (i < 5)       drive_cycle(1'b1, patt[$urandom_range(0, 15)], 1'b1, acc);
            else if (i == 5) drive_cycle(1'b1, 7'h06, 1'b0, acc);
            else             drive_cycle(1'b1, 7'h06, 1'b1, acc);
            obs = {seg_ready, busy, done, bad, digits};
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL mid_reset cyc%0d: got %h expected %h", i, obs, model_vec());
            end
        end
        vectors++;
        if (done !== 1'b1 || digits !== 32'h11111111) begin
            miscompares++;
            $display("FAIL mid_reset_frame: done=%b digits=%h expected 1/11111111", done, digits);
        end
        drive_cycle(1'b0, 7'h00, 1'b1, acc);
    endtask

    task automatic test_back_to_back();
        logic [6:0] f [16];
        logic acc;
        logic [42:0] obs;
        int k = 0;
        int cyc = 0;
        foreach (f[i]) f[i] = patt[$urandom_range(0, 15)];
        while (k < 16 && cyc < 40) begin
            drive_cycle(1'b1, f[k], 1'b1, acc);
            if (acc) k++;
            cyc++;
            obs = {seg_ready, busy, done, bad, digits};
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL back_to_back cyc%0d: got %h expected %h", cyc, obs, model_vec());
            end
        end
        drive_cycle(1'b0, 7'h00, 1'b1, acc);
    endtask

    task automatic test_random();
        logic acc;
        logic [42:0] obs;
        logic [6:0] s;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 7) == 0) ? 7'($urandom) : patt[$urandom_range(0, 15)];
            drive_cycle($urandom_range(0, 3) != 0, s, $urandom_range(0, 60) != 0, acc);
            obs = {seg_ready, busy, done, bad, digits};
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL random cyc%0d: got %h expected %h", i, obs, model_vec());
            end
        end
        drive_cycle(1'b0, 7'h00, 1'b0, acc);
    endtask

`ifdef SS_READER_NINESCOMP_EN
    task automatic test_comp();
        logic [6:0] f [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h77};
        logic acc;
        drive_cycle(1'b0, 7'h00, 1'b1, acc);
        vectors++;
        if (comp !== 32'h0) begin
            miscompares++;
            $display("FAIL comp_reset: got %h expected 00000000", comp);
        end
        for (int i = 0; i < 8; i++) drive_cycle(1'b1, f[i], 1'b1, acc);
        vectors++;
        if (comp !== 32'h98765430 || comp !== m_comp || digits !== 32'h0123456A) begin
            miscompares++;
            $display("FAIL comp_frame: comp=%h digits=%h expected 98765430/0123456a", comp, digits);
        end
        drive_cycle(1'b0, 7'h00, 1'b1, acc);
    endtask
`endif

    initial begin
        test_reset();
        test_known_frame();
        test_toggle_valid();
        test_bad_patterns();
        test_mid_reset();
        test_back_to_back();
        test_random();
`ifdef SS_READER_NINESCOMP_EN
        test_comp();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
